dds_freq_meter: RTL

Measurement-side counterpart of `waveform_gen`. It consumes a 12-bit unsigned sample stream, such as a DDS `sin_out`/`squ_out` or an ADC capture of it. Over a gate window of 2^GATE_LOG2 valid samples it counts rising zero crossings. From that count it recovers the DDS phase increment that would produce the observed tone. It sits beside the DDS core on the Nios/Qsys side for loopback self-test and frequency readback.

---
 rtl/dds_pkg.sv | 19 +
 rtl/crossing_detect.sv | 59 +++++
 rtl/dds_freq_meter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS generator and the frequency meter:
// phase width, meter FSM states and the offset-binary midscale helper.
package dds_pkg;

  localparam int PHASE_W = 32;

  typedef enum logic [1:0] {
    FM_IDLE = 2'd0,
    FM_ARM  = 2'd1,
    FM_GATE = 2'd2,
    FM_DONE = 2'd3
  } fm_state_t;

  // Midscale of an offset-binary sample of the given width.
  function automatic int midscale(input int data_w);
    return 1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/crossing_detect.sv
// Midscale comparator with level register; flags rising zero crossings.
// FREQ_METER_HYST_EN adds a +/-HYST band around midscale.
module crossing_detect
  import dds_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int HYST   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic              init,
  input  logic [DATA_W-1:0] sample_in,
  output logic              rise,
  output logic              level
);

  logic level_q, level_d;

`ifdef FREQ_METER_HYST_EN
  localparam logic [DATA_W:0] MID    = (DATA_W+1)'(midscale(DATA_W));
  localparam logic [DATA_W:0] HI_THR = (DATA_W+1)'(midscale(DATA_W) + HYST);
  localparam logic [DATA_W:0] LO_THR = (DATA_W+1)'(midscale(DATA_W) - HYST);

  always_comb begin
    level_d = level_q;
    if (sample_valid) begin
      if (init) begin
        level_d = ({1'b0, sample_in} >= MID);
      end else if ({1'b0, sample_in} >= HI_THR) begin
        level_d = 1'b1;
      end else if ({1'b0, sample_in} < LO_THR) begin
        level_d = 1'b0;
      end
    end
  end
`else
  // Without hysteresis, "at or above midscale" is just the sample MSB.
  always_comb begin
    level_d = level_q;
    if (sample_valid) begin
      level_d = sample_in[DATA_W-1];
    end
  end
`endif

  // The init sample only seeds the level; it never reports a crossing.
  assign rise  = sample_valid & ~init & ~level_q & level_d;
  assign level = level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/dds_freq_meter.sv
// Gated zero-crossing frequency meter: counts rising crossings over 2^GATE_LOG2
// valid samples and converts the count to a DDS phase increment.
// Optional hysteresis comparator: define FREQ_METER_HYST_EN.
module dds_freq_meter
  import dds_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int GATE_LOG2 = 16,
  parameter int HYST      = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sample_valid,
  input  logic [DATA_W-1:0]    sample_in,
  output logic                 busy,
  output logic                 done,
  output logic [GATE_LOG2:0]   edge_count,
  output logic [PHASE_W-1:0]   phase_inc_est,
  output logic [GATE_LOG2:0]   last_period,
  output fm_state_t            state_dbg
);

  localparam int CNT_W = GATE_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_LAST = {1'b0, {GATE_LOG2{1'b1}}};

  fm_state_t        state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edges_q, edges_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] per_reg_q, per_reg_d;
  logic [CNT_W-1:0] edge_out_q, edge_out_d;
  logic [CNT_W-1:0] per_out_q, per_out_d;
  logic [PHASE_W-1:0] phase_out_q, phase_out_d;

  logic det_valid, det_init, det_rise, det_level;

  assign det_valid = sample_valid & ((state_q == FM_ARM) | (state_q == FM_GATE));
  assign det_init  = (state_q == FM_ARM);

  crossing_detect #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_crossing_detect (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (det_valid),
    .init         (det_init),
    .sample_in    (sample_in),
    .rise         (det_rise),
    .level        (det_level)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    edges_d     = edges_q;
    per_cnt_d   = per_cnt_q;
    per_reg_d   = per_reg_q;
    edge_out_d  = edge_out_q;
    per_out_d   = per_out_q;
    phase_out_d = phase_out_q;

    case (state_q)
      FM_IDLE: begin
        if (start) begin
          state_d   = FM_ARM;
          win_d     = '0;
          edges_d   = '0;
          per_cnt_d = '0;
          per_reg_d = '0;
        end
      end
      FM_ARM: begin
        if (sample_valid) begin
          state_d = FM_GATE;
        end
      end
      FM_GATE: begin
        if (sample_valid) begin
          win_d = win_q + 1'b1;
          if (det_rise) begin
            // The first crossing of a window has no predecessor to measure from.
            if (edges_q != '0) begin
              per_reg_d = per_cnt_q;
            end
            edges_d   = edges_q + 1'b1;
            per_cnt_d = CNT_W'(1);
          end else if (per_cnt_q != '1) begin
            per_cnt_d = per_cnt_q + 1'b1;
          end
          // Results are captured with the final sample so they line up with done.
          if (win_q == WIN_LAST) begin
            state_d     = FM_DONE;
            edge_out_d  = edges_d;
            per_out_d   = per_reg_d;
            phase_out_d = PHASE_W'(edges_d) << (PHASE_W - GATE_LOG2);
          end
        end
      end
      FM_DONE: begin
        state_d = FM_IDLE;
      end
      default: begin
        state_d = FM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FM_IDLE;
      win_q       <= '0;
      edges_q     <= '0;
      per_cnt_q   <= '0;
      per_reg_q   <= '0;
      edge_out_q  <= '0;
      per_out_q   <= '0;
      phase_out_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      edges_q     <= edges_d;
      per_cnt_q   <= per_cnt_d;
      per_reg_q   <= per_reg_d;
      edge_out_q  <= edge_out_d;
      per_out_q   <= per_out_d;
      phase_out_q <= phase_out_d;
    end
  end

  assign busy          = (state_q == FM_ARM) | (state_q == FM_GATE);
  assign done          = (state_q == FM_DONE);
  assign edge_count    = edge_out_q;
  assign phase_inc_est = phase_out_q;
  assign last_period   = per_out_q;
  assign state_dbg     = state_q;

endmodule
